// File: rtl/flit_sink_rx_pkg.sv
// Shared types for the credit-based flit receiver: flit kinds, receive FSM
// states and the tag stored alongside each buffered flit.
package flit_sink_rx_pkg;

    typedef enum logic [1:0] {
        KIND_HDR     = 2'd0,
        KIND_SIZE    = 2'd1,
        KIND_PAYLOAD = 2'd2
    } flit_kind_t;

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_SIZE    = 2'd1,
        S_PAYLOAD = 2'd2
    } rx_state_t;

    // FIFO entry is {tag, data}; the data width follows the top-level FLIT_SIZE.
    typedef struct packed {
        flit_kind_t kind;
        logic       last;
    } entry_tag_t;

    localparam int TAG_W = $bits(entry_tag_t);

endpackage

// File: rtl/flit_sink_fifo.sv
// Parameterised synchronous FIFO with occupancy count and async active-low reset.
// Writes while full and reads while empty are ignored.
module flit_sink_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [PW-1:0] PTR_ONE_C = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    assign full_s  = (count_r == CNT_MAX_C);
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = push_i && !full_s;
    assign pop_s   = pop_i && !empty_s;
    assign dout_o  = mem_r[rd_ptr_r];
    assign count_o = count_r;

    // Storage array; cleared on reset so a stale head never reappears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din_i;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
        end
    end

    // Occupancy tracking; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/flit_sink_rx.sv
// Credit-based flit receiver: classifies header/size/payload flits, buffers them
// with kind and last-of-packet tags, and counts completed packets.
// Optional sticky protocol-error detection is built when FLIT_SINK_ERR_EN is defined.
module flit_sink_rx
    import flit_sink_rx_pkg::*;
#(
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [FLIT_SIZE-1:0] out_data_o,
    output logic [1:0]           out_kind_o,
    output logic                 out_last_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt_o,
    output logic                 err_o
);

    localparam int                   CW        = $clog2(BUFFER_DEPTH) + 1;
    localparam int                   EW        = TAG_W + FLIT_SIZE;
    localparam logic [CW-1:0]        DEPTH_C   = CW'(BUFFER_DEPTH);
    localparam logic [FLIT_SIZE-1:0] REM_ONE_C = FLIT_SIZE'(1'b1);
    localparam logic [CNT_WIDTH-1:0] PKT_ONE_C = CNT_WIDTH'(1'b1);

    rx_state_t              state_r;
    logic [FLIT_SIZE-1:0]   remaining_r;
    logic [CNT_WIDTH-1:0]   pkt_cnt_r;
    logic [CW-1:0]          fifo_count_s;
    logic                   credit_s;
    logic                   accept_s;
    logic                   pop_s;
    entry_tag_t             push_tag_s;
    entry_tag_t             head_tag_s;
    logic [EW-1:0]          head_entry_s;

    // Credit depends on registered occupancy only, never on rx_i or out_ready_i.
    assign credit_s    = (fifo_count_s != DEPTH_C);
    assign accept_s    = rx_i && credit_s;
    assign out_valid_o = (fifo_count_s != {CW{1'b0}});
    assign pop_s       = out_valid_o && out_ready_i;

    // Tag the incoming flit according to where we are in the packet.
    always_comb begin
        push_tag_s.kind = KIND_HDR;
        push_tag_s.last = 1'b0;
        case (state_r)
            S_HEADER: begin
                push_tag_s.kind = KIND_HDR;
                push_tag_s.last = 1'b0;
            end
            S_SIZE: begin
                push_tag_s.kind = KIND_SIZE;
                push_tag_s.last = (data_i == {FLIT_SIZE{1'b0}});
            end
            S_PAYLOAD: begin
                push_tag_s.kind = KIND_PAYLOAD;
                push_tag_s.last = (remaining_r == REM_ONE_C);
            end
            default: begin
                push_tag_s.kind = KIND_HDR;
                push_tag_s.last = 1'b0;
            end
        endcase
    end

    flit_sink_fifo #(
        .WIDTH (EW),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept_s),
        .din_i   ({push_tag_s, data_i}),
        .pop_i   (pop_s),
        .dout_o  (head_entry_s),
        .count_o (fifo_count_s)
    );

    assign head_tag_s = head_entry_s[EW-1:FLIT_SIZE];
    assign out_data_o = head_entry_s[FLIT_SIZE-1:0];
    assign out_kind_o = head_tag_s.kind;
    assign out_last_o = head_tag_s.last;
    assign credit_o   = credit_s;
    assign pkt_cnt_o  = pkt_cnt_r;

    // Receive FSM; advances only on accepted flits and counts finished packets.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= S_HEADER;
            remaining_r <= {FLIT_SIZE{1'b0}};
            pkt_cnt_r   <= {CNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            case (state_r)
                S_HEADER: begin
                    state_r <= S_SIZE;
                end
                S_SIZE: begin
                    remaining_r <= data_i;
                    if (push_tag_s.last) begin
                        pkt_cnt_r <= pkt_cnt_r + PKT_ONE_C;
                        state_r   <= S_HEADER;
                    end else begin
                        state_r   <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    remaining_r <= remaining_r - REM_ONE_C;
                    if (push_tag_s.last) begin
                        pkt_cnt_r <= pkt_cnt_r + PKT_ONE_C;
                        state_r   <= S_HEADER;
                    end else begin
                        state_r   <= S_PAYLOAD;
                    end
                end
                default: begin
                    state_r <= S_HEADER;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

`ifdef FLIT_SINK_ERR_EN
    logic err_r;

    // Sticky error: credit overrun or an all-ones (reserved) header word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if ((rx_i && !credit_s) ||
                     (accept_s && (state_r == S_HEADER) && (data_i == {FLIT_SIZE{1'b1}}))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_flit_sink_rx.sv
// Directed self-checking bench for flit_sink_rx: table-driven basic packets
// plus hand-written backpressure, reset and random-ready sequences.
module tb_flit_sink_rx;

    logic        clk_i;
    logic        rst_ni;
    logic        rx_i;
    logic        credit_o;
    logic [31:0] data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [1:0]  out_kind_o;
    logic        out_last_o;
    logic [15:0] pkt_cnt_o;
    logic        err_o;

    int checks;
    int errors;

    flit_sink_rx #(
        .FLIT_SIZE    (32),
        .BUFFER_DEPTH (8),
        .CNT_WIDTH    (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .credit_o    (credit_o),
        .data_i      (data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_kind_o  (out_kind_o),
        .out_last_o  (out_last_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rx;
        logic [31:0] data;
        logic        ready;
        logic        e_credit;
        logic        e_valid;
        logic [31:0] e_data;
        logic [1:0]  e_kind;
        logic        e_last;
        logic [15:0] e_pkt;
    } vec_t;

    vec_t tbl [9];

    logic [31:0] bp_data [8];
    logic [1:0]  bp_kind [8];
    logic [31:0] bb_data [7];
    logic [1:0]  bb_kind [7];
    logic        bb_last [7];

    logic exp_err_on;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        rst_ni = 1'b0;
        rx_i = 1'b0;
        #3;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        int sent;
        int got;
        int cyc;
        logic drive;

        checks = 0;
        errors = 0;
`ifdef FLIT_SINK_ERR_EN
        exp_err_on = 1'b1;
`else
        exp_err_on = 1'b0;
`endif
        rst_ni = 1'b0;
        rx_i = 1'b0;
        data_i = 32'h0;
        out_ready_i = 1'b0;

        tbl[0] = '{1'b1, 32'h00000102, 1'b1, 1'b1, 1'b1, 32'h00000102, 2'd0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 32'h00000003, 1'b1, 1'b1, 1'b1, 32'h00000003, 2'd1, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 32'h0000000A, 1'b1, 1'b1, 1'b1, 32'h0000000A, 2'd2, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 32'h0000000B, 1'b1, 1'b1, 1'b1, 32'h0000000B, 2'd2, 1'b0, 16'd0};
        tbl[4] = '{1'b1, 32'h0000000C, 1'b1, 1'b1, 1'b1, 32'h0000000C, 2'd2, 1'b1, 16'd1};
        tbl[5] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b0, 16'd1};
        tbl[6] = '{1'b1, 32'h00000101, 1'b1, 1'b1, 1'b1, 32'h00000101, 2'd0, 1'b0, 16'd1};
        tbl[7] = '{1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'h00000000, 2'd1, 1'b1, 16'd2};
        tbl[8] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b0, 16'd2};

        bp_data = '{32'h200, 32'h14, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        bp_kind = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        bb_data = '{32'h301, 32'h1, 32'hAA, 32'h302, 32'h2, 32'hBB, 32'hCC};
        bb_kind = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2};
        bb_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values
        #12;
        chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_credit", {63'd0, credit_o}, 64'd1);
        chk("rst_pkt", {48'd0, pkt_cnt_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Basic 3-payload packet then zero-size packet, ready held high
        for (int i = 0; i < 9; i++) begin
            rx_i = tbl[i].rx;
            data_i = tbl[i].data;
            out_ready_i = tbl[i].ready;
            tick();
            chk($sformatf("tbl%0d_credit", i), {63'd0, credit_o}, {63'd0, tbl[i].e_credit});
            chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid_o}, {63'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_pkt", i), {48'd0, pkt_cnt_o}, {48'd0, tbl[i].e_pkt});
            chk($sformatf("tbl%0d_err", i), {63'd0, err_o}, 64'd0);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_data", i), {32'd0, out_data_o}, {32'd0, tbl[i].e_data});
                chk($sformatf("tbl%0d_kind", i), {62'd0, out_kind_o}, {62'd0, tbl[i].e_kind});
                chk($sformatf("tbl%0d_last", i), {63'd0, out_last_o}, {63'd0, tbl[i].e_last});
            end
        end
        rx_i = 1'b0;

        // Backpressure: 12 flits offered with consumer stalled
        out_ready_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            rx_i = 1'b1;
            data_i = (k == 0) ? 32'h200 : ((k == 1) ? 32'd20 : 32'(k - 1));
            tick();
            chk($sformatf("bp%0d_credit", k), {63'd0, credit_o}, (k < 7) ? 64'd1 : 64'd0);
            chk($sformatf("bp%0d_head", k), {32'd0, out_data_o}, 64'h200);
            chk($sformatf("bp%0d_kind", k), {62'd0, out_kind_o}, 64'd0);
            chk($sformatf("bp%0d_err", k), {63'd0, err_o}, {63'd0, exp_err_on && (k >= 8)});
        end
        rx_i = 1'b0;
        out_ready_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d_valid", j), {63'd0, out_valid_o}, 64'd1);
            chk($sformatf("drain%0d_data", j), {32'd0, out_data_o}, {32'd0, bp_data[j]});
            chk($sformatf("drain%0d_kind", j), {62'd0, out_kind_o}, {62'd0, bp_kind[j]});
            tick();
        end
        chk("drain_empty", {63'd0, out_valid_o}, 64'd0);
        chk("drain_credit", {63'd0, credit_o}, 64'd1);
        chk("drain_err_sticky", {63'd0, err_o}, {63'd0, exp_err_on});

        // Reset asserted mid-payload
        pulse_reset();
        out_ready_i = 1'b0;
        rx_i = 1'b1; data_i = 32'h400; tick();
        data_i = 32'd4; tick();
        data_i = 32'h41; tick();
        rx_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("midrst_credit", {63'd0, credit_o}, 64'd1);
        chk("midrst_err", {63'd0, err_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        rx_i = 1'b1; data_i = 32'h500; tick();
        chk("postrst_kind", {62'd0, out_kind_o}, 64'd0);
        chk("postrst_data", {32'd0, out_data_o}, 64'h500);
        data_i = 32'd0; tick();
        rx_i = 1'b0;
        chk("postrst_pkt", {48'd0, pkt_cnt_o}, 64'd1);

        // Back-to-back packets (sizes 1 and 2) with random ready
        pulse_reset();
        sent = 0;
        got = 0;
        cyc = 0;
        while ((got < 7) && (cyc < 300)) begin
            drive = (sent < 7) && credit_o;
            rx_i = drive;
            data_i = (sent < 7) ? bb_data[sent] : 32'h0;
            out_ready_i = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (out_valid_o && out_ready_i) begin
                chk($sformatf("bb%0d_data", got), {32'd0, out_data_o}, {32'd0, bb_data[got]});
                chk($sformatf("bb%0d_kind", got), {62'd0, out_kind_o}, {62'd0, bb_kind[got]});
                chk($sformatf("bb%0d_last", got), {63'd0, out_last_o}, {63'd0, bb_last[got]});
                got++;
            end
            @(posedge clk_i);
            #1;
            if (drive) sent++;
            cyc++;
        end
        rx_i = 1'b0;
        chk("bb_count", 64'(got), 64'd7);
        chk("bb_pkt", {48'd0, pkt_cnt_o}, 64'd2);
        chk("bb_empty", {63'd0, out_valid_o}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
